// File: rtl/transform_pkg.sv
// Shared definitions for the transformation datapath sequencer.
package transform_pkg;

  localparam int COORD_W      = 8;
  localparam int H_PIX_DEF    = 160;
  localparam int V_PIX_DEF    = 120;
  localparam int PIPE_LAT_DEF = 5;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SCAN,
    ST_DRAIN,
    ST_FIN
  } scan_state_t;

endpackage

// File: rtl/transform_scan_ctrl_valid_delay_line.sv
// Valid-flag shift register tracking pixels in flight through the datapath.
module valid_delay_line #(
  parameter int DEPTH = 5
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_din,
  output logic o_tap_last
);

  logic [DEPTH-1:0] r_sh;

  generate
    if (DEPTH == 1) begin : g_one
      always_ff @(posedge i_clk) begin
        if (i_rst) r_sh <= '0;
        else       r_sh <= i_din;
      end
    end else begin : g_shift
      always_ff @(posedge i_clk) begin
        if (i_rst) r_sh <= '0;
        else       r_sh <= {r_sh[DEPTH-2:0], i_din};
      end
    end
  endgenerate

  assign o_tap_last = r_sh[DEPTH-1];

endmodule

// File: rtl/transform_scan_ctrl.sv
// Frame sequencer: rasters source pixels into the transform datapath and
// qualifies the datapath's write outputs with a matching valid delay line.
module transform_scan_ctrl
  import transform_pkg::*;
#(
  parameter int H_PIX    = H_PIX_DEF,
  parameter int V_PIX    = V_PIX_DEF,
  parameter int PIPE_LAT = PIPE_LAT_DEF
) (
  input  logic               ACLK,
  input  logic               ARESET,
  input  logic               START,
  input  logic               ENB,
  input  logic [COORD_W-1:0] CFG_XC,
  input  logic [COORD_W-1:0] CFG_YC,
  input  logic [COORD_W-1:0] CFG_ZOOM,
  input  logic [COORD_W-1:0] CFG_ANGLE,
  output logic [COORD_W-1:0] Xcoord,
  output logic [COORD_W-1:0] Ycoord,
  output logic [COORD_W-1:0] Xcenter,
  output logic [COORD_W-1:0] Ycenter,
  output logic [COORD_W-1:0] Zoom,
  output logic [COORD_W-1:0] Angle,
  input  logic [COORD_W-1:0] T_ADDR,
  input  logic               T_WRITE,
  output logic               WR_EN,
  output logic [COORD_W-1:0] WR_ADDR,
  output logic               BUSY,
  output logic               DONE
);

  localparam int DW = $clog2(PIPE_LAT + 2);
  localparam logic [COORD_W-1:0] X_LAST = COORD_W'(H_PIX - 1);
  localparam logic [COORD_W-1:0] Y_LAST = COORD_W'(V_PIX - 1);
  localparam logic [COORD_W-1:0] C_ONE  = COORD_W'(1);

  scan_state_t       r_state;
  logic [COORD_W-1:0] r_x;
  logic [COORD_W-1:0] r_y;
  logic [DW-1:0]      r_drain;
  logic               w_push;
  logic               w_tap;
  logic               w_wr;

  always_comb begin
    w_push = (r_state == ST_SCAN) && ENB;
    w_wr   = w_tap & T_WRITE;
  end

  valid_delay_line #(.DEPTH(PIPE_LAT)) u_vdl (
    .i_clk      (ACLK),
    .i_rst      (ARESET),
    .i_din      (w_push),
    .o_tap_last (w_tap)
  );

  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      r_state <= ST_IDLE;
      r_x     <= '0;
      r_y     <= '0;
      r_drain <= '0;
      Xcoord  <= '0;
      Ycoord  <= '0;
      Xcenter <= '0;
      Ycenter <= '0;
      Zoom    <= '0;
      Angle   <= '0;
      BUSY    <= 1'b0;
      DONE    <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          DONE <= 1'b0;
          if (START) begin
            Xcenter <= CFG_XC;
            Ycenter <= CFG_YC;
            Zoom    <= CFG_ZOOM;
            Angle   <= CFG_ANGLE;
            r_x     <= '0;
            r_y     <= '0;
            BUSY    <= 1'b1;
            r_state <= ST_SCAN;
          end
        end
        ST_SCAN: begin
          if (ENB) begin
            Xcoord <= r_x;
            Ycoord <= r_y;
            if (r_x == X_LAST && r_y == Y_LAST) begin
              r_drain <= DW'(PIPE_LAT + 1);
              r_state <= ST_DRAIN;
            end else if (r_x == X_LAST) begin
              r_x <= '0;
              r_y <= r_y + C_ONE;
            end else begin
              r_x <= r_x + C_ONE;
            end
          end
        end
        ST_DRAIN: begin
          // Reaching 1 here means the counter hits 0 on this edge.
          r_drain <= r_drain - DW'(1);
          if (r_drain == DW'(1)) begin
            BUSY    <= 1'b0;
            DONE    <= 1'b1;
            r_state <= ST_FIN;
          end
        end
        ST_FIN: begin
          DONE    <= 1'b0;
          r_state <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      WR_EN   <= 1'b0;
      WR_ADDR <= '0;
    end else begin
      WR_EN <= w_wr;
      if (w_wr) WR_ADDR <= T_ADDR;
    end
  end

endmodule

// File: tb/tb_transform_scan_ctrl.sv
// Directed bench for transform_scan_ctrl with a write scoreboard and a
// stub datapath that turns issued coordinates into y*H+x addresses.
module tb_transform_scan_ctrl;

  localparam int H   = 4;
  localparam int V   = 2;
  localparam int LAT = 5;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst, start, start1, enb, t_write;
  logic [7:0] cfg_xc, cfg_yc, cfg_zoom, cfg_angle;
  logic [7:0] xc0, yc0, xcen0, ycen0, zoom0, angle0, t_addr0, wr_addr0;
  logic       wr_en0, busy0, done0;
  logic [7:0] xc1, yc1, xcen1, ycen1, zoom1, angle1, wr_addr1;
  logic [7:0] t_addr1;
  logic       wr_en1, busy1, done1;

  transform_scan_ctrl #(.H_PIX(H), .V_PIX(V), .PIPE_LAT(LAT)) u0 (
    .ACLK(clk), .ARESET(rst), .START(start), .ENB(enb),
    .CFG_XC(cfg_xc), .CFG_YC(cfg_yc), .CFG_ZOOM(cfg_zoom), .CFG_ANGLE(cfg_angle),
    .Xcoord(xc0), .Ycoord(yc0), .Xcenter(xcen0), .Ycenter(ycen0),
    .Zoom(zoom0), .Angle(angle0), .T_ADDR(t_addr0), .T_WRITE(t_write),
    .WR_EN(wr_en0), .WR_ADDR(wr_addr0), .BUSY(busy0), .DONE(done0)
  );

  transform_scan_ctrl #(.H_PIX(1), .V_PIX(1), .PIPE_LAT(LAT)) u1 (
    .ACLK(clk), .ARESET(rst), .START(start1), .ENB(enb),
    .CFG_XC(cfg_xc), .CFG_YC(cfg_yc), .CFG_ZOOM(cfg_zoom), .CFG_ANGLE(cfg_angle),
    .Xcoord(xc1), .Ycoord(yc1), .Xcenter(xcen1), .Ycenter(ycen1),
    .Zoom(zoom1), .Angle(angle1), .T_ADDR(t_addr1), .T_WRITE(t_write),
    .WR_EN(wr_en1), .WR_ADDR(wr_addr1), .BUSY(busy1), .DONE(done1)
  );

  assign t_addr1 = 8'hA5;

  // Stub datapath: coordinates seen on Xcoord/Ycoord emerge LAT-1 cycles later
  logic [7:0] px [LAT-1];
  logic [7:0] py [LAT-1];
  always @(posedge clk) begin
    px[0] <= xc0;
    py[0] <= yc0;
    for (int i = 1; i < LAT - 1; i++) begin
      px[i] <= px[i-1];
      py[i] <= py[i-1];
    end
  end
  always_comb t_addr0 = 8'(int'(py[LAT-2]) * H + int'(px[LAT-2]));

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks   = 0;
  int errors   = 0;
  int done_cnt = 0;
  int wr_total = 0;

  typedef struct {
    int         cyc;
    logic [7:0] addr;
  } exp_t;
  exp_t sb[$];
  exp_t mon_e;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    if (done0 === 1'b1) done_cnt++;
    if (wr_en0 === 1'b1) begin
      wr_total++;
      if (sb.size() == 0) begin
        chk("wr_unexpected", {31'b0, wr_en0}, 32'd0);
      end else begin
        mon_e = sb.pop_front();
        chk("wr_cycle", cyc, mon_e.cyc);
        chk("wr_addr", {24'b0, wr_addr0}, {24'b0, mon_e.addr});
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input int x, input int y, input bit expect_wr);
    exp_t e;
    if (expect_wr) begin
      e.cyc  = cyc + LAT + 1;
      e.addr = 8'(y * H + x);
      sb.push_back(e);
    end
    enb = 1'b1;
    tick();
    chk("xcoord", {24'b0, xc0}, x);
    chk("ycoord", {24'b0, yc0}, y);
    chk("busy_scan", {31'b0, busy0}, 32'd1);
  endtask

  task automatic wait_done(input string tag, input int exp_cyc);
    int found = 0;
    for (int n = 0; n < 40 && found == 0; n++) begin
      if (done0 === 1'b1) found = 1;
      else tick();
    end
    chk({tag, "_done_seen"}, found, 32'd1);
    chk({tag, "_done_cycle"}, cyc, exp_cyc);
    chk({tag, "_sb_empty"}, sb.size(), 32'd0);
    tick();
    chk({tag, "_done_pulse"}, {31'b0, done0}, 32'd0);
    chk({tag, "_busy_idle"}, {31'b0, busy0}, 32'd0);
  endtask

  initial begin
    int s;
    int wr_before;
    int found;

    rst = 1'b1; start = 1'b0; start1 = 1'b0; enb = 1'b0; t_write = 1'b1;
    cfg_xc = '0; cfg_yc = '0; cfg_zoom = '0; cfg_angle = '0;
    repeat (3) tick();
    chk("rst_xcoord", {24'b0, xc0}, 0);
    chk("rst_ycoord", {24'b0, yc0}, 0);
    chk("rst_zoom", {24'b0, zoom0}, 0);
    chk("rst_wr_en", {31'b0, wr_en0}, 0);
    chk("rst_wr_addr", {24'b0, wr_addr0}, 0);
    chk("rst_busy", {31'b0, busy0}, 0);
    chk("rst_done", {31'b0, done0}, 0);
    chk("rst_busy1", {31'b0, busy1}, 0);
    rst = 1'b0;
    tick();

    // Frame A: ENB always high, CFG_ZOOM changed and START pulsed mid-frame
    cfg_xc = 8'h11; cfg_yc = 8'h22; cfg_zoom = 8'h10; cfg_angle = 8'h33;
    start = 1'b1;
    s = cyc;
    tick();
    start = 1'b0;
    chk("cfg_xcenter", {24'b0, xcen0}, 32'h11);
    chk("cfg_ycenter", {24'b0, ycen0}, 32'h22);
    chk("cfg_zoom", {24'b0, zoom0}, 32'h10);
    chk("cfg_angle", {24'b0, angle0}, 32'h33);
    chk("busy_start", {31'b0, busy0}, 1);
    for (int i = 0; i < H * V; i++) begin
      if (i == 2) cfg_zoom = 8'h20;
      start = (i == 3);
      issue(i % H, i / H, 1'b1);
      start = 1'b0;
      chk("zoom_hold", {24'b0, zoom0}, 32'h10);
    end
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("busy_drain", {31'b0, busy0}, 1);
    chk("zoom_hold_drain", {24'b0, zoom0}, 32'h10);
    wait_done("frameA", s + 15);
    chk("wr_addr_hold", {24'b0, wr_addr0}, 32'd7);

    // Frame B: three bubble cycles after the second issue
    start = 1'b1;
    s = cyc;
    tick();
    start = 1'b0;
    chk("zoom_new_frame", {24'b0, zoom0}, 32'h20);
    issue(0, 0, 1'b1);
    issue(1, 0, 1'b1);
    for (int b = 0; b < 3; b++) begin
      enb = 1'b0;
      tick();
      chk("bubble_xhold", {24'b0, xc0}, 1);
      chk("bubble_yhold", {24'b0, yc0}, 0);
    end
    for (int i = 2; i < H * V; i++) issue(i % H, i / H, 1'b1);
    wait_done("frameB", s + 18);

    // Frame C: reset after third issue, in-flight pixels must never write
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 3; i++) issue(i, 0, 1'b0);
    wr_before = wr_total;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("abort_xcoord", {24'b0, xc0}, 0);
    chk("abort_xcenter", {24'b0, xcen0}, 0);
    chk("abort_zoom", {24'b0, zoom0}, 0);
    chk("abort_busy", {31'b0, busy0}, 0);
    chk("abort_done", {31'b0, done0}, 0);
    chk("abort_wr_en", {31'b0, wr_en0}, 0);
    enb = 1'b1;
    repeat (15) tick();
    chk("abort_no_writes", wr_total, wr_before);
    chk("abort_idle", {31'b0, busy0}, 0);

    // Frame D: 1x1 frame on the second instance
    start1 = 1'b1;
    s = cyc;
    tick();
    start1 = 1'b0;
    enb = 1'b1;
    tick();
    chk("one_xcoord", {24'b0, xc1}, 0);
    chk("one_busy", {31'b0, busy1}, 1);
    found = 0;
    for (int n = 0; n < 20 && found == 0; n++) begin
      if (wr_en1 === 1'b1) found = 1;
      else tick();
    end
    chk("one_wr_seen", found, 1);
    chk("one_wr_cycle", cyc, s + 1 + LAT + 1);
    chk("one_wr_addr", {24'b0, wr_addr1}, 32'hA5);
    tick();
    chk("one_done", {31'b0, done1}, 1);
    chk("one_wr_single", {31'b0, wr_en1}, 0);
    tick();
    chk("one_done_pulse", {31'b0, done1}, 0);
    chk("one_busy_idle", {31'b0, busy1}, 0);

    chk("done_count", done_cnt, 2);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
